// File: rtl/l1d_cache_gen2.sv
// l1d_cache_gen2: blocking, write-back, write-allocate L1 data cache.
// N-way set associative with age-based replacement and full-line memory
// transactions. Optional flush-all engine enabled by defining L1D_FLUSH_EN.
module l1d_cache_gen2 #(
    parameter int NUM_WAYS       = 4,
    parameter int NUM_SETS       = 64,
    parameter int WORDS_PER_LINE = 16,
    localparam int LINE_BITS     = 32 * WORDS_PER_LINE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [31:0]          req_addr,
    input  logic                 req_we,
    input  logic [3:0]           req_be,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    input  logic                 flush,
    output logic                 flush_done,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [LINE_BITS-1:0] mem_wdata,
    input  logic                 mem_ack,
    input  logic [LINE_BITS-1:0] mem_rdata,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int WO_W  = $clog2(WORDS_PER_LINE);
    localparam int OFF_W = WO_W + 2;
    localparam int TAG_W = 32 - OFF_W - IDX_W;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOOKUP    = 3'd1,
        S_WRITEBACK = 3'd2,
        S_REFILL    = 3'd3,
        S_RESPOND   = 3'd4
`ifdef L1D_FLUSH_EN
        , S_FLUSH   = 3'd5
`endif
    } state_t;

    function automatic logic [31:0] get_word(input logic [LINE_BITS-1:0] line, input logic [WO_W-1:0] w);
        return line[{w, 5'd0} +: 32];
    endfunction

    function automatic logic [LINE_BITS-1:0] put_word(input logic [LINE_BITS-1:0] line, input logic [WO_W-1:0] w,
                                                      input logic [31:0] d);
        logic [LINE_BITS-1:0] r;
        r = line;
        r[{w, 5'd0} +: 32] = d;
        return r;
    endfunction

    function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    // Storage: data/tag arrays are never reset; valid, dirty and age are.
    logic [LINE_BITS-1:0] data_mem [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]     tag_mem  [NUM_SETS][NUM_WAYS];
    logic                 valid_q  [NUM_SETS][NUM_WAYS];
    logic                 dirty_q  [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]     age_q    [NUM_SETS][NUM_WAYS];

    state_t               state_q, state_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [31:0]          resp_rdata_q, resp_rdata_d;
    logic                 mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic [LINE_BITS-1:0] mem_wdata_q, mem_wdata_d;
    logic [31:0]          hit_count_q, hit_count_d, miss_count_q, miss_count_d;
    logic [TAG_W-1:0]     req_tag_q, req_tag_d;
    logic [IDX_W-1:0]     req_idx_q, req_idx_d;
    logic [WO_W-1:0]      req_word_q, req_word_d;
    logic                 req_we_q, req_we_d;
    logic [3:0]           req_be_q, req_be_d;
    logic [31:0]          req_wdata_q, req_wdata_d;
    logic [WAY_W-1:0]     victim_q, victim_d;

    logic                 hit, inv_found;
    logic [WAY_W-1:0]     hit_way, vict_way;
    logic                 line_we, tag_we, meta_we, meta_valid, meta_dirty, age_upd;
    logic [WAY_W-1:0]     line_way, meta_way, age_way;
    logic [IDX_W-1:0]     meta_set;
    logic [LINE_BITS-1:0] line_data, look_line;
    logic [31:0]          look_word, look_merged, fill_word, fill_merged;
    logic [1:0]           unused_addr;

`ifdef L1D_FLUSH_EN
    localparam int FP_W = IDX_W + WAY_W;
    logic                 flush_done_q, flush_done_d;
    logic [FP_W-1:0]      flush_ptr_q, flush_ptr_d;
    logic [IDX_W-1:0]     f_set;
    logic [WAY_W-1:0]     f_way;
    assign f_set      = flush_ptr_q[WAY_W +: IDX_W];
    assign f_way      = flush_ptr_q[WAY_W-1:0];
    assign req_ready  = (state_q == S_IDLE) && !flush;
    assign flush_done = flush_done_q;
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign req_ready    = (state_q == S_IDLE);
    assign flush_done   = 1'b0;
`endif

    assign unused_addr = req_addr[1:0];
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign hit_count   = hit_count_q;
    assign miss_count  = miss_count_q;

    assign look_line   = data_mem[req_idx_q][hit_way];
    assign look_word   = get_word(look_line, req_word_q);
    assign look_merged = merge_be(look_word, req_wdata_q, req_be_q);
    assign fill_word   = get_word(mem_rdata, req_word_q);
    assign fill_merged = merge_be(fill_word, req_wdata_q, req_be_q);

    // Tag match and victim choice (lowest invalid way, else the age-0 way).
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        vict_way  = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[req_idx_q][w] && tag_mem[req_idx_q][w] == req_tag_q && !hit) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!valid_q[req_idx_q][w] && !inv_found) begin
                inv_found = 1'b1;
                vict_way  = WAY_W'(w);
            end
        end
        if (!inv_found) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (age_q[req_idx_q][w] == '0) vict_way = WAY_W'(w);
            end
        end
    end

    // Next-state, registered outputs and array write controls.
    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        req_tag_d    = req_tag_q;
        req_idx_d    = req_idx_q;
        req_word_d   = req_word_q;
        req_we_d     = req_we_q;
        req_be_d     = req_be_q;
        req_wdata_d  = req_wdata_q;
        victim_d     = victim_q;
        line_we      = 1'b0;
        tag_we       = 1'b0;
        line_way     = hit_way;
        line_data    = look_line;
        meta_we      = 1'b0;
        meta_set     = req_idx_q;
        meta_way     = hit_way;
        meta_valid   = 1'b1;
        meta_dirty   = 1'b0;
        age_upd      = 1'b0;
        age_way      = hit_way;
`ifdef L1D_FLUSH_EN
        flush_done_d = 1'b0;
        flush_ptr_d  = flush_ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef L1D_FLUSH_EN
                if (flush) begin
                    flush_ptr_d = '0;
                    state_d     = S_FLUSH;
                end else
`endif
                if (req_valid) begin
                    req_tag_d   = req_addr[31 -: TAG_W];
                    req_idx_d   = req_addr[OFF_W +: IDX_W];
                    req_word_d  = req_addr[2 +: WO_W];
                    req_we_d    = req_we;
                    req_be_d    = req_be;
                    req_wdata_d = req_wdata;
                    state_d     = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    hit_count_d  = hit_count_q + 32'd1;
                    age_upd      = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = req_we_q ? look_merged : look_word;
                    if (req_we_q) begin
                        line_we    = 1'b1;
                        line_data  = put_word(look_line, req_word_q, look_merged);
                        meta_we    = 1'b1;
                        meta_dirty = 1'b1;
                    end
                    state_d = S_RESPOND;
                end else begin
                    miss_count_d = miss_count_q + 32'd1;
                    victim_d     = vict_way;
                    mem_req_d    = 1'b1;
                    if (valid_q[req_idx_q][vict_way] && dirty_q[req_idx_q][vict_way]) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {tag_mem[req_idx_q][vict_way], req_idx_q, {OFF_W{1'b0}}};
                        mem_wdata_d = data_mem[req_idx_q][vict_way];
                        state_d     = S_WRITEBACK;
                    end else begin
                        mem_we_d   = 1'b0;
                        mem_addr_d = {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
                        state_d    = S_REFILL;
                    end
                end
            end
            S_WRITEBACK: begin
                if (mem_req_q && mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = S_REFILL;
                end
            end
            S_REFILL: begin
                // After a writeback mem_req is low for one cycle; raise it here.
                if (!mem_req_q) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
                end else if (mem_ack) begin
                    mem_req_d    = 1'b0;
                    line_we      = 1'b1;
                    tag_we       = 1'b1;
                    line_way     = victim_q;
                    line_data    = req_we_q ? put_word(mem_rdata, req_word_q, fill_merged) : mem_rdata;
                    meta_we      = 1'b1;
                    meta_way     = victim_q;
                    meta_dirty   = req_we_q;
                    age_upd      = 1'b1;
                    age_way      = victim_q;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = req_we_q ? fill_merged : fill_word;
                    state_d      = S_RESPOND;
                end
            end
            S_RESPOND: state_d = S_IDLE;
`ifdef L1D_FLUSH_EN
            S_FLUSH: begin
                meta_set = f_set;
                meta_way = f_way;
                if (mem_req_q) begin
                    // Writeback done: keep the line valid but clean, then revisit it.
                    if (mem_ack) begin
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                        meta_we   = 1'b1;
                    end
                end else if (valid_q[f_set][f_way] && dirty_q[f_set][f_way]) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {tag_mem[f_set][f_way], f_set, {OFF_W{1'b0}}};
                    mem_wdata_d = data_mem[f_set][f_way];
                end else begin
                    meta_we    = 1'b1;
                    meta_valid = 1'b0;
                    if (flush_ptr_q == {FP_W{1'b1}}) begin
                        flush_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        flush_ptr_d = flush_ptr_q + FP_W'(1);
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Control state: FSM, pulses, memory request handshake, counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
`ifdef L1D_FLUSH_EN
            flush_done_q <= 1'b0;
            flush_ptr_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
`ifdef L1D_FLUSH_EN
            flush_done_q <= flush_done_d;
            flush_ptr_q  <= flush_ptr_d;
`endif
        end
    end

    // Datapath registers: latched request fields and memory payload.
    always_ff @(posedge clk) begin
        mem_addr_q  <= mem_addr_d;
        mem_wdata_q <= mem_wdata_d;
        req_tag_q   <= req_tag_d;
        req_idx_q   <= req_idx_d;
        req_word_q  <= req_word_d;
        req_we_q    <= req_we_d;
        req_be_q    <= req_be_d;
        req_wdata_q <= req_wdata_d;
        victim_q    <= victim_d;
    end

    // Line data and tag arrays.
    always_ff @(posedge clk) begin
        if (line_we) data_mem[req_idx_q][line_way] <= line_data;
        if (tag_we)  tag_mem[req_idx_q][line_way]  <= req_tag_q;
    end

    // Valid/dirty bits and replacement ages.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= WAY_W'(w);
                end
            end
        end else begin
            if (meta_we) begin
                valid_q[meta_set][meta_way] <= meta_valid;
                dirty_q[meta_set][meta_way] <= meta_dirty;
            end
            if (age_upd) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (WAY_W'(w) == age_way)
                        age_q[req_idx_q][w] <= WAY_W'(NUM_WAYS - 1);
                    else if (age_q[req_idx_q][w] > age_q[req_idx_q][age_way])
                        age_q[req_idx_q][w] <= age_q[req_idx_q][w] - WAY_W'(1);
                end
            end
        end
    end
endmodule

// File: doc/l1d_cache_gen2.md
L1D_CACHE_GEN2 -- requirements
Module: l1d_cache_gen2

Interface
REQ-001 SHALL provide parameter NUM_WAYS, default 4, associativity (power of 2, 2..8).
REQ-002 SHALL provide parameter NUM_SETS, default 64, set count (power of 2).
REQ-003 SHALL provide parameter WORDS_PER_LINE, default 16, 32-bit words per line (power of 2); LINE_BITS = 32*WORDS_PER_LINE.
REQ-004 SHALL provide ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  CPU request
- req_ready  out  1  request accepted when both high
- req_addr  in  32  byte address; [1:0] ignored
- req_we  in  1  1 = write
- req_be  in  4  byte enables for writes
- req_wdata  in  32  write data
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  read data, valid with resp_valid
- flush  in  1  flush-all request
- flush_done  out  1  one-cycle flush completion pulse
- mem_req  out  1  memory transaction request
- mem_we  out  1  1 = line writeback, 0 = line refill
- mem_addr  out  32  line-aligned address
- mem_wdata  out  LINE_BITS  writeback line
- mem_ack  in  1  transaction complete, one cycle
- mem_rdata  in  LINE_BITS  refill line, valid with mem_ack
- hit_count  out  32  hit counter
- miss_count  out  32  miss counter

Function
REQ-005 Address split SHALL be: offset = log2(WORDS_PER_LINE)+2 bits, index = log2(NUM_SETS) bits, tag = remainder.
REQ-006 SHALL implement FSM IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND, FLUSH; req_ready = 1 only in IDLE.
REQ-007 Accept edge: IDLE -> LOOKUP, latching addr/we/be/wdata.
REQ-008 LOOKUP on hit: hit_count += 1, -> RESPOND; resp_valid fires in the cycle after LOOKUP, 2 cycles after accept.
REQ-009 LOOKUP on miss: miss_count += 1; victim dirty -> WRITEBACK, else -> REFILL.
REQ-010 WRITEBACK: mem_req=1, mem_we=1, mem_addr = victim line base, mem_wdata = victim line; all held until mem_ack, then -> REFILL.
REQ-011 REFILL: mem_req=1, mem_we=0, mem_addr = request line base, held until mem_ack; on ack install mem_rdata, set tag and valid, clear dirty, -> RESPOND.
REQ-012 mem_req SHALL drop in the cycle after mem_ack; mem_ack outside WRITEBACK/REFILL/FLUSH is ignored.
REQ-013 Write: merge only bytes with req_be set into the word, set dirty (even when req_be = 0); resp_rdata = merged word.
REQ-014 Read: resp_rdata = addressed word, including the freshly refilled line on a miss.
REQ-015 Victim: lowest-index invalid way, else the way with age 0.
REQ-016 Ages: log2(NUM_WAYS)-bit per way; on hit or fill, ways with age above the used way's old age decrement by 1, used way set to NUM_WAYS-1.
REQ-017 Counters SHALL wrap modulo 2^32.
REQ-018 When flush and req_valid are both high in IDLE, flush SHALL take priority.

Reset
REQ-019 rst SHALL force IDLE and clear resp_valid, resp_rdata, mem_req, mem_we, flush_done, hit_count, miss_count, all valid and dirty bits.
REQ-020 rst SHALL set way w age = w; data and tag arrays are not reset.
REQ-021 rst mid-transaction SHALL abandon it; mem_req is 0 in the cycle after rst, with no resp_valid.

Configuration
REQ-022 Macro L1D_FLUSH_EN defined: flush in IDLE -> FLUSH. Every set/way is visited in order; each dirty line is written back per REQ-010 handshake; all valid/dirty bits are cleared; flush_done pulses; -> IDLE.
REQ-023 Macro L1D_FLUSH_EN undefined: flush ignored, flush_done tied 0, no FLUSH state.

Verification
REQ-024 Cold read 0x00001000, mem_ack with word0 = 0xDEADBEEF -> mem_addr 0x00001000, mem_we 0, resp_rdata 0xDEADBEEF, miss_count 1; repeat read -> resp_valid 2 cycles after accept, no mem_req, hit_count 1.
REQ-025 Line word1 = 0x12345678; write 0x00001004, be 0b0011, wdata 0xAAAA5555 -> read 0x00001004 returns 0x12345555.
REQ-026 Write 0x00000000, then read 0x1000, 0x2000, 0x3000, 0x4000 (set 0) -> at 0x4000: writeback mem_we 1, mem_addr 0x0, then refill mem_addr 0x4000.
REQ-027 Read A=0x0, B=0x1000, C=0x2000, D=0x3000, reread A, read 0x4000 -> B's way replaced; reread A hits.
REQ-028 L1D_FLUSH_EN, two dirty lines, flush -> exactly two mem_we=1 transactions, one flush_done pulse, next read of either address misses.
REQ-029 rst asserted in REFILL before mem_ack -> mem_req 0 next cycle, req_ready 1, hit_count and miss_count 0.
